// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - core-wide pipeline constants, IF/ID bundle and fetch state enum
package fetch_stage_pkg;

    localparam int XLEN = 32;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN,
        FAULTED
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    pc4;
        logic [INSTR_W-1:0] instr;
        logic               valid;
        logic               fault;
    } if_id_t;

    // Empty slot: addi x0,x0,0 with no PC association.
    function automatic if_id_t bubble_slot();
        if_id_t b;
        b.pc    = '0;
        b.pc4   = '0;
        b.instr = NOP_INSTR;
        b.valid = 1'b0;
        b.fault = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with stall hold and bubble insert
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    // A bubble must win over hold so that flush during a stall still empties the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= bubble_slot();
        end else if (bubble) begin
            q <= bubble_slot();
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, fault FSM and IF/ID register
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int IMEM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic            if_id_fault,
    output logic [31:0]     fetch_count
);

    localparam logic [XLEN-1:0] LAST_PC = XLEN'(IMEM_BYTES - 4);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     count_q;
    logic            count_inc;
    logic            pc_legal;
    logic            slot_bubble;
    logic            slot_hold;
    if_id_t          slot_d, slot_q;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);
    assign imem_addr = pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (count_inc) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        count_inc    = 1'b0;
        slot_bubble  = 1'b0;
        slot_hold    = 1'b0;
        slot_d.pc    = pc_q;
        slot_d.pc4   = pc_plus4;
        slot_d.instr = imem_instr;
        slot_d.valid = 1'b1;
        slot_d.fault = 1'b0;

        if (redirect) begin
            pc_d        = redirect_pc;
            state_d     = RUN;
            slot_bubble = 1'b1;
        end else if (stall) begin
            slot_hold   = 1'b1;
            slot_bubble = flush;
        end else if (state_q == RUN) begin
            if (pc_legal) begin
                pc_d        = pc_plus4;
                slot_bubble = flush;
                count_inc   = !flush;
            end else if (flush) begin
                // Killed slot: stay in RUN so the fault is reported on the next unflushed cycle.
                slot_bubble = 1'b1;
            end else begin
                slot_d.instr = NOP_INSTR;
                slot_d.fault = 1'b1;
                state_d      = FAULTED;
            end
        end else begin
            slot_bubble = 1'b1;
        end
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .hold   (slot_hold),
        .bubble (slot_bubble),
        .d      (slot_d),
        .q      (slot_q)
    );

    assign if_id_pc    = slot_q.pc;
    assign if_id_pc4   = slot_q.pc4;
    assign if_id_instr = slot_q.instr;
    assign if_id_valid = slot_q.valid;
    assign if_id_fault = slot_q.fault;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven directed bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        if_id_fault;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fetch_stage #(.IMEM_BYTES(1024)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .if_id_fault (if_id_fault),
        .fetch_count (fetch_count)
    );

    // Instruction memory model: three plan words, then 0xA000_0000 | word index.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        if (addr >= 32'd1024) return 32'hDEAD_BEEF;
        case (idx)
            32'd0:   return 32'h015a_09b3;
            32'd1:   return 32'h0023_6633;
            32'd2:   return 32'h0073_6aa3;
            default: return 32'hA000_0000 | idx;
        endcase
    endfunction

    assign imem_instr = mem_word(imem_addr);

    typedef struct {
        logic        s;
        logic        f;
        logic        r;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] rpc,
                                input logic [31:0] addr, input logic [31:0] pc, input logic [31:0] instr,
                                input logic valid, input logic fault, input logic [31:0] cnt);
        vec_t v;
        v.s = s; v.f = f; v.r = r; v.rpc = rpc; v.addr = addr;
        v.pc = pc; v.instr = instr; v.valid = valid; v.fault = fault; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic check_slot(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                              input logic [31:0] instr, input logic valid, input logic fault,
                              input logic [31:0] cnt);
        check({tag, ".pc"}, if_id_pc, pc);
        check({tag, ".pc4"}, if_id_pc4, pc4);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
        check({tag, ".fault"}, {31'd0, if_id_fault}, {31'd0, fault});
        check({tag, ".count"}, fetch_count, cnt);
    endtask

    initial begin
        // s f r rpc | imem_addr before edge | IF/ID after edge: pc instr valid fault count
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h000, 32'h000, 32'h015a09b3, 1'b1, 1'b0, 32'd1);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h004, 32'h004, 32'h00236633, 1'b1, 1'b0, 32'd2);
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   32'h008, 32'h004, 32'h00236633, 1'b1, 1'b0, 32'd2);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   32'h008, 32'h004, 32'h00236633, 1'b1, 1'b0, 32'd2);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h008, 32'h008, 32'h00736aa3, 1'b1, 1'b0, 32'd3);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h00C, 32'h00C, 32'hA0000003, 1'b1, 1'b0, 32'd4);
        vecs[6]  = mk(1'b0, 1'b0, 1'b1, 32'h20,  32'h010, 32'h000, NOP,          1'b0, 1'b0, 32'd4);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h020, 32'h020, 32'hA0000008, 1'b1, 1'b0, 32'd5);
        vecs[8]  = mk(1'b1, 1'b0, 1'b1, 32'h40,  32'h024, 32'h000, NOP,          1'b0, 1'b0, 32'd5);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h040, 32'h040, 32'hA0000010, 1'b1, 1'b0, 32'd6);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 32'h0,   32'h044, 32'h000, NOP,          1'b0, 1'b0, 32'd6);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h044, 32'h044, 32'hA0000011, 1'b1, 1'b0, 32'd7);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 32'h0,   32'h048, 32'h000, NOP,          1'b0, 1'b0, 32'd7);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h04C, 32'h04C, 32'hA0000013, 1'b1, 1'b0, 32'd8);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 32'h22,  32'h050, 32'h000, NOP,          1'b0, 1'b0, 32'd8);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h022, 32'h022, NOP,          1'b1, 1'b1, 32'd8);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h022, 32'h000, NOP,          1'b0, 1'b0, 32'd8);
        vecs[17] = mk(1'b1, 1'b0, 1'b0, 32'h0,   32'h022, 32'h000, NOP,          1'b0, 1'b0, 32'd8);
        vecs[18] = mk(1'b0, 1'b0, 1'b1, 32'h0,   32'h022, 32'h000, NOP,          1'b0, 1'b0, 32'd8);
        vecs[19] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h000, 32'h000, 32'h015a09b3, 1'b1, 1'b0, 32'd9);
        vecs[20] = mk(1'b0, 1'b0, 1'b1, 32'h3F8, 32'h004, 32'h000, NOP,          1'b0, 1'b0, 32'd9);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h3F8, 32'h3F8, 32'hA00000FE, 1'b1, 1'b0, 32'd10);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h3FC, 32'h3FC, 32'hA00000FF, 1'b1, 1'b0, 32'd11);
        vecs[23] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h400, 32'h400, NOP,          1'b1, 1'b1, 32'd11);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset.imem_addr", imem_addr, 32'h0);
        check_slot("reset", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < 24; i++) begin
            stall = vecs[i].s;
            flush = vecs[i].f;
            redirect = vecs[i].r;
            redirect_pc = vecs[i].rpc;
            #1;
            check($sformatf("v%0d.imem_addr", i), imem_addr, vecs[i].addr);
            @(posedge clk);
            #1;
            check_slot($sformatf("v%0d", i), vecs[i].pc,
                       vecs[i].valid ? vecs[i].pc + 32'd4 : 32'h0,
                       vecs[i].instr, vecs[i].valid, vecs[i].fault, vecs[i].cnt);
        end
        stall = 1'b0; flush = 1'b0; redirect = 1'b0;

        // FAULTED at 0x400 holds the PC; reset with competing inputs must still win.
        #1;
        check("fault_hold.imem_addr", imem_addr, 32'h400);
        redirect = 1'b1; redirect_pc = 32'h100; stall = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; redirect = 1'b0; stall = 1'b0;
        check("midreset.imem_addr", imem_addr, 32'h0);
        check_slot("midreset", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);

        // PC+4 wraps modulo 2^32 on a faulting top-of-space PC.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        check("wrap.imem_addr", imem_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        check_slot("wrap", 32'hFFFF_FFFC, 32'h0, NOP, 1'b1, 1'b1, 32'd0);

        // Recovery from FAULTED via redirect resumes counted fetch.
        redirect = 1'b1; redirect_pc = 32'h4;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(posedge clk);
        #1;
        check_slot("recover", 32'h4, 32'h8, 32'h00236633, 1'b1, 1'b0, 32'd1);
        check("recover.imem_addr", imem_addr, 32'h8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipelined RISC-V core. Owns the program counter, drives the byte address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register. Handles hazard-unit stalls, EX-stage branch/jump redirects, ID flushes and fetch faults. It sits directly upstream of the instruction memory and directly feeds the decode stage.

## Interface
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- IMEM_BYTES, 1024, addressable instruction-memory bytes; legal PCs are 0..IMEM_BYTES-4
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit: hold PC and IF/ID
- flush  in  1  kill the IF/ID contents
- redirect  in  1  EX stage: taken branch/jump
- redirect_pc  in  32  redirect target
- imem_addr  out  32  byte address to instruction memory, equal to PC
- imem_instr  in  32  combinational read data for imem_addr
- if_id_pc  out  32  PC of the latched instruction
- if_id_pc4  out  32  if_id_pc + 4
- if_id_instr  out  32  latched instruction
- if_id_valid  out  1  latched slot holds a real instruction
- if_id_fault  out  1  latched slot is a fetch fault
- fetch_count  out  32  count of valid, non-fault instructions latched

## Operation
- States: RUN, FAULTED. Reset -> RUN.
- Per-cycle priority: reset > redirect > stall > flush > normal.
- reset: PC=RESET_PC; if_id_pc=0, if_id_pc4=0, if_id_instr=NOP_INSTR, if_id_valid=0, if_id_fault=0; fetch_count=0; state RUN.
- redirect (any state, stall ignored): PC<=redirect_pc; IF/ID <= bubble (NOP_INSTR, valid 0, fault 0); state<=RUN.
- stall without redirect: PC, IF/ID, fetch_count hold. If flush is also high, the IF/ID slot becomes a bubble and PC still holds.
- flush alone: IF/ID <= bubble; PC advances as normal.
- normal in RUN with a legal PC: IF/ID <= {PC, PC+4, imem_instr, valid 1, fault 0}; PC<=PC+4; fetch_count++.
- Illegal PC means PC[1:0]!=0 or PC>IMEM_BYTES-4. In RUN, a normal cycle with an illegal PC latches {PC, PC+4, NOP_INSTR, valid 1, fault 1}. PC holds and state<=FAULTED; fetch_count is unchanged.
- FAULTED: PC holds. Without flush/stall, IF/ID loads a bubble each cycle. Only redirect or reset exits.
- Arithmetic: PC+4 is modulo 2^32. fetch_count wraps 2^32-1 -> 0.
- imem_addr = PC combinationally, including during stall.

## Timing
- Fetch latency: 1 cycle. The PC presented in cycle N produces IF/ID outputs valid after the edge ending cycle N.
- Redirect penalty: redirect in cycle N gives a bubble in IF/ID during N+1. The target's instruction is in IF/ID during N+2.
- Stall is level-sensitive. An S-cycle stall holds the IF/ID outputs for exactly S cycles.
- Reset mid-operation: all state takes its reset values at the next edge, regardless of other inputs.
- All outputs are registered except imem_addr.

## Structure
- Shared package (core-wide pipeline package): NOP_INSTR, XLEN, RESET_PC, the IF/ID bundle field widths, and the fetch state enum {RUN, FAULTED}.
- One natural sub-module: if_id_reg, the IF/ID register with stall hold, bubble insert and reset. The PC/next-PC/FSM logic stays in fetch_stage.

## Test plan
- Reset, then 4 free-running cycles over memory words 0x015a09b3 @0, 0x00236633 @4, 0x00736aa3 @8 -> IF/ID shows pc 0/4/8 with those words, valid 1. fetch_count=3 after the third latch.
- Stall high for 2 cycles while if_id_pc=4 -> IF/ID and imem_addr unchanged for 2 cycles, then pc 8 latched.
- Redirect to 0x20 with imem_addr=0x10 -> next cycle bubble (0x00000013, valid 0). The cycle after: if_id_pc=0x20, instr=mem[0x20].
- Redirect and stall in the same cycle -> redirect wins; PC=target next cycle. Flush and stall together -> bubble, PC held.
- Redirect to 0x22 -> slot latched with fault 1, instr NOP, valid 1; FAULTED with PC held at 0x22. A later redirect to 0x0 -> RUN, fetch resumes at 0.
- Fetch reaches PC=0x3FC then 0x400 (IMEM_BYTES=1024) -> 0x3FC is fetched normally; 0x400 faults. Reset mid-fault -> PC=0, valid 0, count 0.
